// File: rtl/simd_p_accumulator_if.sv
// rtl/simd_p_accumulator_if.sv - control, beat-stream and result handshake bundle for simd_p_accumulator
interface simd_p_accumulator_if #(
    parameter int WIDTH = 32,
    parameter int LEN_W = 8
);
    logic [1:0]         use_simd;
    logic [LEN_W-1:0]   acc_len;
    logic               start;
    logic [WIDTH-1:0]   s;
    logic [WIDTH/8-1:0] s_carry;
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   p;
    logic [WIDTH/8-1:0] p_ovf;
    logic               out_valid;
    logic               out_ready;
    logic               busy;
    logic               err_mode;

    modport master (
        output use_simd, acc_len, start, s, s_carry, in_valid, out_ready,
        input  in_ready, p, p_ovf, out_valid, busy, err_mode
    );

    modport slave (
        input  use_simd, acc_len, start, s, s_carry, in_valid, out_ready,
        output in_ready, p, p_ovf, out_valid, busy, err_mode
    );
endinterface

// File: rtl/simd_p_accumulator.sv
// rtl/simd_p_accumulator.sv - lane-wise SIMD accumulator of ALU sums into P with sticky per-lane overflow
module simd_p_accumulator #(
    parameter int WIDTH = 32,
    parameter int LEN_W = 8
) (
    input logic              clk,
    input logic              rst_n,
    simd_p_accumulator_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCUM  = 2'd1,
        ST_OUTPUT = 2'd2
    } state_t;

    localparam logic [1:0] MODE_1X32 = 2'b00;
    localparam logic [1:0] MODE_2X16 = 2'b01;
    localparam logic [1:0] MODE_4X8  = 2'b10;
    localparam logic [1:0] MODE_BAD  = 2'b11;

    state_t             state_r;
    state_t             state_nxt;
    logic [1:0]         mode_r;
    logic [LEN_W:0]     len_r;
    logic [LEN_W:0]     cnt_r;
    logic [LEN_W:0]     cnt_inc;
    logic [WIDTH-1:0]   p_r;
    logic [3:0]         ovf_r;
    logic               err_r;

    logic               start_fire;
    logic               start_legal;
    logic               beat_fire;
    logic               last_beat;
    logic               in_ready_c;

    logic [3:0]         lane_brk;
    logic [3:0]         top_mask;
    logic [3:0]         byte_carry;
    logic [WIDTH-1:0]   sum_word;

    assign start_fire  = (state_r == ST_IDLE) && bus.start;
    assign start_legal = bus.use_simd != MODE_BAD;
    assign beat_fire   = bus.in_valid && in_ready_c;
    assign cnt_inc     = cnt_r + 1'b1;
    assign last_beat   = beat_fire && (cnt_inc == len_r);

    // lane_brk[b] kills the carry entering byte b; top_mask marks each lane's top byte
    always_comb begin
        lane_brk = 4'b0000;
        top_mask = 4'b1000;
        case (mode_r)
            MODE_2X16: begin lane_brk = 4'b0100; top_mask = 4'b1010; end
            MODE_4X8:  begin lane_brk = 4'b1110; top_mask = 4'b1111; end
            default:   begin lane_brk = 4'b0000; top_mask = 4'b1000; end
        endcase
    end

    always_comb begin
        logic       c;
        logic [8:0] bsum;
        c          = 1'b0;
        bsum       = 9'd0;
        sum_word   = '0;
        byte_carry = 4'b0000;
        for (int b = 0; b < 4; b++) begin
            c             = c & ~lane_brk[b];
            bsum          = {1'b0, p_r[8*b +: 8]} + {1'b0, bus.s[8*b +: 8]} + {8'd0, c};
            sum_word[8*b +: 8] = bsum[7:0];
            byte_carry[b] = bsum[8];
            c             = bsum[8];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state_r;
        in_ready_c = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start_fire && start_legal) begin
                    state_nxt = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                in_ready_c = 1'b1;
                if (last_beat) begin
                    state_nxt = ST_OUTPUT;
                end
            end
            ST_OUTPUT: begin
                if (bus.out_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_r <= MODE_1X32;
            len_r  <= '0;
            cnt_r  <= '0;
            p_r    <= '0;
            ovf_r  <= 4'b0000;
            err_r  <= 1'b0;
        end else begin
            if (start_fire && start_legal) begin
                mode_r <= bus.use_simd;
                len_r  <= (bus.acc_len == '0) ? {{LEN_W{1'b0}}, 1'b1} : {1'b0, bus.acc_len};
                cnt_r  <= '0;
                p_r    <= '0;
                ovf_r  <= 4'b0000;
            end
            if (start_fire && !start_legal) begin
                err_r <= 1'b1;
            end
            // Overflow is sticky and only ever lands on a lane's top byte slot
            if (beat_fire) begin
                p_r   <= sum_word;
                ovf_r <= ovf_r | ((byte_carry | bus.s_carry) & top_mask);
                cnt_r <= cnt_inc;
            end
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = state_r == ST_OUTPUT;
    assign bus.busy      = state_r != ST_IDLE;
    assign bus.p         = p_r;
    assign bus.p_ovf     = ovf_r;
    assign bus.err_mode  = err_r;
endmodule

// File: tb/tb_simd_p_accumulator.sv
// tb/tb_simd_p_accumulator.sv - table-driven directed bench for simd_p_accumulator
module tb_simd_p_accumulator;
    logic clk = 1'b0;
    logic rst_n;

    simd_p_accumulator_if #(.WIDTH(32), .LEN_W(8)) bus ();

    simd_p_accumulator #(.WIDTH(32), .LEN_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]       mode;
        logic [7:0]       len;
        logic [2:0]       nb;
        logic [3:0][31:0] s;
        logic [3:0][3:0]  sc;
        logic [31:0]      exp_p;
        logic [3:0]       exp_ovf;
    } vec_t;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [1:0] mode, input logic [7:0] len, input logic [2:0] nb,
                                input logic [31:0] s0, input logic [31:0] s1,
                                input logic [31:0] s2, input logic [31:0] s3,
                                input logic [3:0] c0, input logic [3:0] c1,
                                input logic [3:0] c2, input logic [3:0] c3,
                                input logic [31:0] ep, input logic [3:0] eo);
        vec_t v;
        v.mode = mode; v.len = len; v.nb = nb;
        v.s[0] = s0; v.s[1] = s1; v.s[2] = s2; v.s[3] = s3;
        v.sc[0] = c0; v.sc[1] = c1; v.sc[2] = c2; v.sc[3] = c3;
        v.exp_p = ep; v.exp_ovf = eo;
        return v;
    endfunction

    // Starts an accumulation, feeds nb beats, leaves the DUT in OUTPUT
    task automatic run_vec(input vec_t v, input string tag);
        @(negedge clk);
        bus.use_simd = v.mode;
        bus.acc_len  = v.len;
        bus.start    = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check({tag, ".busy_start"}, {31'd0, bus.busy}, 32'd1);
        check({tag, ".p_cleared"}, bus.p, 32'd0);
        for (int i = 0; i < int'(v.nb); i++) begin
            bus.s        = v.s[i];
            bus.s_carry  = v.sc[i];
            bus.in_valid = 1'b1;
            check({tag, ".in_ready"}, {31'd0, bus.in_ready}, 32'd1);
            @(negedge clk);
            if (i < int'(v.nb) - 1)
                check({tag, ".early_valid"}, {31'd0, bus.out_valid}, 32'd0);
        end
        bus.in_valid = 1'b0;
        bus.s_carry  = 4'd0;
        check({tag, ".out_valid"}, {31'd0, bus.out_valid}, 32'd1);
        check({tag, ".p"}, bus.p, v.exp_p);
        check({tag, ".p_ovf"}, {28'd0, bus.p_ovf}, {28'd0, v.exp_ovf});
        check({tag, ".in_ready_out"}, {31'd0, bus.in_ready}, 32'd0);
    endtask

    task automatic finish_out(input logic [31:0] exp_p, input string tag);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check({tag, ".valid_drop"}, {31'd0, bus.out_valid}, 32'd0);
        check({tag, ".busy_idle"}, {31'd0, bus.busy}, 32'd0);
        check({tag, ".p_hold_idle"}, bus.p, exp_p);
    endtask

    vec_t vecs[7];

    initial begin
        vecs[0] = mk(2'b00, 8'd3, 3'd3, 32'h00000001, 32'h00000002, 32'h00000003, 32'h0,
                     4'h0, 4'h0, 4'h0, 4'h0, 32'h00000006, 4'b0000);
        vecs[1] = mk(2'b10, 8'd2, 3'd2, 32'hFF010203, 32'h02010101, 32'h0, 32'h0,
                     4'h0, 4'h0, 4'h0, 4'h0, 32'h01020304, 4'b1000);
        vecs[2] = mk(2'b01, 8'd1, 3'd1, 32'h00010002, 32'h0, 32'h0, 32'h0,
                     4'b0010, 4'h0, 4'h0, 4'h0, 32'h00010002, 4'b0010);
        vecs[3] = mk(2'b00, 8'd2, 3'd2, 32'hFFFFFFFF, 32'h00000002, 32'h0, 32'h0,
                     4'h0, 4'h0, 4'h0, 4'h0, 32'h00000001, 4'b1000);
        vecs[4] = mk(2'b01, 8'd2, 3'd2, 32'hFFFF0001, 32'h00010001, 32'h0, 32'h0,
                     4'h0, 4'h0, 4'h0, 4'h0, 32'h00000002, 4'b1000);
        vecs[5] = mk(2'b10, 8'd2, 3'd2, 32'h01010101, 32'h01010101, 32'h0, 32'h0,
                     4'b0010, 4'h0, 4'h0, 4'h0, 32'h02020202, 4'b0010);
        vecs[6] = mk(2'b01, 8'd4, 3'd4, 32'h0000FFFF, 32'h00000001, 32'h7FFF0000, 32'h80000000,
                     4'h0, 4'h0, 4'h0, 4'h0, 32'hFFFF0000, 4'b0010);

        rst_n         = 1'b0;
        bus.use_simd  = 2'b00;
        bus.acc_len   = 8'd0;
        bus.start     = 1'b0;
        bus.s         = 32'd0;
        bus.s_carry   = 4'd0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst.p", bus.p, 32'd0);
        check("rst.p_ovf", {28'd0, bus.p_ovf}, 32'd0);
        check("rst.out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst.in_ready", {31'd0, bus.in_ready}, 32'd0);
        check("rst.busy", {31'd0, bus.busy}, 32'd0);
        check("rst.err_mode", {31'd0, bus.err_mode}, 32'd0);
        rst_n = 1'b1;

        for (int k = 0; k < 7; k++) begin
            run_vec(vecs[k], $sformatf("vec%0d", k));
            finish_out(vecs[k].exp_p, $sformatf("vec%0d", k));
        end

        // Backpressure: result held, stray beats ignored, START during handshake ignored
        run_vec(vecs[1], "bp");
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1;
            bus.s        = 32'hDEADBEEF;
            bus.s_carry  = 4'hF;
            @(negedge clk);
            check("bp.out_valid", {31'd0, bus.out_valid}, 32'd1);
            check("bp.p_stable", bus.p, 32'h01020304);
            check("bp.ovf_stable", {28'd0, bus.p_ovf}, 32'h8);
            check("bp.in_ready", {31'd0, bus.in_ready}, 32'd0);
        end
        bus.in_valid  = 1'b0;
        bus.s_carry   = 4'd0;
        bus.use_simd  = 2'b00;
        bus.start     = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.start     = 1'b0;
        bus.out_ready = 1'b0;
        check("bp.busy_idle", {31'd0, bus.busy}, 32'd0);
        check("bp.valid_drop", {31'd0, bus.out_valid}, 32'd0);
        @(negedge clk);
        check("bp.start_ignored", {31'd0, bus.busy}, 32'd0);
        check("bp.p_hold", bus.p, 32'h01020304);

        // Illegal mode
        bus.use_simd = 2'b11;
        bus.start    = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check("err.err_mode", {31'd0, bus.err_mode}, 32'd1);
        check("err.busy", {31'd0, bus.busy}, 32'd0);
        @(negedge clk);
        check("err.still_idle", {31'd0, bus.busy}, 32'd0);
        run_vec(vecs[2], "err_after");
        finish_out(vecs[2].exp_p, "err_after");
        check("err.sticky", {31'd0, bus.err_mode}, 32'd1);

        // Reset mid-accumulation
        @(negedge clk);
        bus.use_simd = 2'b00;
        bus.acc_len  = 8'd4;
        bus.start    = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.s        = 32'h00000010;
            bus.in_valid = 1'b1;
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        check("mid.p_partial", bus.p, 32'h00000020);
        rst_n = 1'b0;
        #1;
        check("mid.p", bus.p, 32'd0);
        check("mid.busy", {31'd0, bus.busy}, 32'd0);
        check("mid.in_ready", {31'd0, bus.in_ready}, 32'd0);
        check("mid.out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("mid.err_mode", {31'd0, bus.err_mode}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_vec(mk(2'b00, 8'd0, 3'd1, 32'h00000005, 32'h0, 32'h0, 32'h0,
                   4'h0, 4'h0, 4'h0, 4'h0, 32'h00000005, 4'b0000), "len0");
        finish_out(32'h00000005, "len0");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
